retire_stage: RTL and testbench
===============================

# retire_stage

In-order retirement stage that sits directly upstream of the cycle/CPI counter. Instructions are allocated in program order into a circular commit buffer and marked complete out of order by tag. Each cycle the stage retires up to RET_W consecutive completed entries from the head. It drives the counter's retire-count (`W_v`) and halt (`isHalt`) inputs.

## Interface

Parameters:
- `DEPTH`, 8: commit-buffer entries; power of two, 2..64.
- `RET_W`, 3: maximum retirements per cycle; 1..7 so the count fits in `W_v`.
- `TAG_W`, log2(DEPTH): derived; do not override.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset; asynchronous, active-low.
- `alloc_v` input 1: allocate one instruction this cycle.
- `alloc_halt` input 1: the allocated instruction is a halt.
- `alloc_ready` output 1: allocation accepted when `alloc_v && alloc_ready`.
- `alloc_tag` output TAG_W: tag assigned to the allocating instruction (current tail index).
- `cmpl_v` input 2: completion valid, one bit per completion port.
- `cmpl_tag0`, `cmpl_tag1` input TAG_W each: tags being completed.
- `flush` input 1: discard all in-flight entries.
- `W_v` output 3: number of instructions retired, registered.
- `isHalt` output 1: a halt has retired; sticky.
- `occupancy` output TAG_W+1: number of live entries.

## Operation

- **Pointers.** `head` and `tail` are TAG_W+1 bits, with the MSB used as the wrap bit.
  - Empty: `head == tail`.
  - Full: indices equal and wrap bits differ.
  - `occupancy` = `tail - head` (modulo 2^(TAG_W+1)).
- **Entry state.** Each entry holds `{live, done, halt}`.
- **Allocate.**
  - `alloc_ready` = !full && !halted && !flush. It is computed from the current occupancy only; a same-cycle retire does not free a slot for allocation.
  - On accept: entry[tail] <= {1, 0, alloc_halt}; tail increments.
- **Complete.**
  - For each valid port whose tag indexes a live entry, set `done`.
  - A completion to a non-live entry is ignored.
  - Both ports naming the same tag is legal and equivalent to one completion.
- **Retire.**
  - Scan from head for consecutive entries with live && done.
  - Stop at the first non-done entry, at RET_W entries, or after the first halt entry, whichever comes first. The halt itself is retired and counted.
  - Retired entries are cleared; head advances by the count.
- **Halt.**
  - When a halt retires, the sticky flag `halted` sets.
  - While halted: no further retirement or allocation until reset. `W_v` is 0 from the following cycle on.
- **Flush.**
  - Clears all entries; tail <= head.
  - Flush has priority over allocate, complete and retire in the same cycle. The next `W_v` is 0.
  - Flush does not clear `halted`.
- **Reset values.** head = tail = 0; all entries cleared; `W_v` = 0; `isHalt` = 0; `occupancy` = 0; `alloc_ready` = 1 once `rst_n` deasserts.

## Timing

- `alloc_tag` is valid combinationally in the allocating cycle.
- Completion latency: completion at edge t makes the entry retire-eligible at edge t+1. The retire scan uses registered `done` bits, never same-cycle completions.
- `W_v` and `isHalt` are registered from the retire decision: retirement decided in cycle t appears on `W_v` in cycle t+1.
- When the halt retires, `isHalt` is 1 in the same cycle in which `W_v` reports that retirement, and stays 1.
- Pointer wrap is seamless. Retiring across index DEPTH-1 -> 0 in one cycle is legal.
- Asserting `rst_n` mid-operation immediately clears all state and drives every output to its reset value.

## Structure

- **Package `retire_pkg`:** `DEPTH`, `TAG_W`, `RET_W` constants, plus the `entry_t` struct `{live, done, halt}`.
- **Sub-module `retire_select`:** combinational head-window scan.
  - Inputs: RET_W entries starting at head.
  - Outputs: retire count (3 bits) and halt-hit flag.
  - Keeps the priority/stop logic separately testable.
- **Top level:** owns the entry array, pointers, the `halted` flag and the output registers.

## Test plan

- **In-order drain.** Reset, then allocate 5 non-halt instructions (tags 0–4) and complete all at once. Required: `W_v` = 3, then 2, then 0; `occupancy` goes 5 -> 2 -> 0.
- **Out-of-order block.** Allocate tags 0–2; complete 2 then 1, while 0 is withheld. Required: `W_v` = 0. Then complete 0; the next cycle `W_v` = 3.
- **Full and wrap-around.** Fill to 8 entries. Required: `alloc_ready` = 0 while full. Then complete all, retire, and refill through index 7 -> 0. Required: tags wrap to 0, and `occupancy` never exceeds 8.
- **Halt mid-window.** Allocate plain, halt, plain and complete all three. Required: `W_v` = 2 and `isHalt` = 1 in the same cycle. Afterwards `W_v` = 0, `alloc_ready` = 0, and the trailing entry never retires.
- **Flush precedence.** With 4 live entries, assert flush together with alloc_v and a completion. Required: next cycle `occupancy` = 0, `W_v` = 0, and the allocation is not accepted.
- **Async reset.** Assert `rst_n` low mid-retirement, away from a clock edge. Required: `W_v`, `isHalt` and `occupancy` go to 0 immediately; after release, `alloc_tag` = 0.

Source files
------------

// File: rtl/retire_pkg.sv
// rtl/retire_pkg.sv - shared constants and commit-buffer entry type for the retire stage
//
// Purpose: default sizing of the commit buffer and the per-entry state record.
// Ports:   none (package).

package retire_pkg;

    localparam int DEPTH = 8;
    localparam int RET_W = 3;
    localparam int TAG_W = $clog2(DEPTH);

    typedef struct packed {
        logic live;
        logic done;
        logic halt;
    } entry_t;

endpackage

// File: rtl/retire_select.sv
// rtl/retire_select.sv - combinational head-window scan choosing how many entries retire
//
// Purpose: walk the window starting at head and count consecutive live+done
//          entries, stopping at the first non-done entry or just after a halt.
// Ports:
//   win      in  WIN entries, win[0] is the head entry
//   count    out number of entries to retire this cycle (0..WIN)
//   halt_hit out a halt entry is among the retired entries

module retire_select
    import retire_pkg::*;
#(
    parameter int WIN = 3
) (
    input  entry_t [WIN-1:0] win,
    output logic   [2:0]     count,
    output logic             halt_hit
);

    logic stop;

    always_comb begin
        count    = '0;
        halt_hit = 1'b0;
        stop     = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            if (!stop) begin
                if (win[i].live && win[i].done) begin
                    count = count + 3'd1;
                    // The halt itself retires, but nothing younger may follow it.
                    if (win[i].halt) begin
                        halt_hit = 1'b1;
                        stop     = 1'b1;
                    end
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/retire_stage.sv
// rtl/retire_stage.sv - in-order retirement from a circular commit buffer
//
// Purpose: allocate in program order, complete out of order by tag, retire up
//          to RET_W consecutive completed entries per cycle from the head.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   alloc_v, alloc_halt  allocation request and its halt attribute
//   alloc_ready          allocation accepted when alloc_v && alloc_ready
//   alloc_tag            tag given to the allocating instruction (tail index)
//   cmpl_v, cmpl_tag0/1  two completion ports
//   flush                discard all in-flight entries
//   W_v                  registered retire count
//   isHalt               sticky: a halt has retired
//   occupancy            number of live entries

module retire_stage #(
    parameter int DEPTH = retire_pkg::DEPTH,
    parameter int RET_W = retire_pkg::RET_W,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_v,
    input  logic             alloc_halt,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic [1:0]       cmpl_v,
    input  logic [TAG_W-1:0] cmpl_tag0,
    input  logic [TAG_W-1:0] cmpl_tag1,
    input  logic             flush,
    output logic [2:0]       W_v,
    output logic             isHalt,
    output logic [TAG_W:0]   occupancy
);

    import retire_pkg::*;

    // A window wider than the buffer would revisit the head entry.
    localparam int WIN = (RET_W < DEPTH) ? RET_W : DEPTH;

    logic [TAG_W:0]   head;
    logic [TAG_W:0]   tail;
    entry_t           ent [DEPTH];
    logic             halted;
    logic [2:0]       w_q;

    logic             full;
    logic [TAG_W-1:0] head_idx;
    logic [TAG_W-1:0] tail_idx;
    entry_t [WIN-1:0] win;
    logic [2:0]       sel_cnt;
    logic             sel_halt;
    logic [2:0]       ret_cnt;
    logic             ret_halt;

    assign head_idx    = head[TAG_W-1:0];
    assign tail_idx    = tail[TAG_W-1:0];
    assign full        = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
    assign occupancy   = tail - head;
    assign alloc_ready = !full && !halted && !flush;
    assign alloc_tag   = tail_idx;
    assign W_v         = w_q;
    assign isHalt      = halted;

    always_comb begin
        for (int i = 0; i < WIN; i++) begin
            win[i] = ent[head_idx + TAG_W'(i)];
        end
    end

    retire_select #(.WIN(WIN)) u_select (
        .win      (win),
        .count    (sel_cnt),
        .halt_hit (sel_halt)
    );

    // Once halted, the machine is frozen until reset.
    assign ret_cnt  = halted ? 3'd0 : sel_cnt;
    assign ret_halt = !halted && sel_halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head   <= '0;
            tail   <= '0;
            halted <= 1'b0;
            w_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else if (flush) begin
            tail <= head;
            w_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            if (cmpl_v[0] && ent[cmpl_tag0].live) begin
                ent[cmpl_tag0].done <= 1'b1;
            end
            if (cmpl_v[1] && ent[cmpl_tag1].live) begin
                ent[cmpl_tag1].done <= 1'b1;
            end
            // Clearing comes after completion so a late completion to a
            // retiring entry cannot leave it half-alive.
            for (int i = 0; i < WIN; i++) begin
                if (3'(i) < ret_cnt) begin
                    ent[head_idx + TAG_W'(i)] <= '0;
                end
            end
            // The tail slot is never live unless full, so it cannot collide
            // with a retiring or completing entry.
            if (alloc_v && alloc_ready) begin
                ent[tail_idx] <= '{live: 1'b1, done: 1'b0, halt: alloc_halt};
                tail          <= tail + 1'b1;
            end
            head   <= head + (TAG_W+1)'(ret_cnt);
            w_q    <= ret_cnt;
            halted <= halted | ret_halt;
        end
    end

endmodule

// File: tb/tb_retire_stage.sv
// tb/tb_retire_stage.sv - self-checking bench for retire_stage

module tb_retire_stage;

    logic       clk;
    logic       rst_n;
    logic       alloc_v;
    logic       alloc_halt;
    logic       alloc_ready;
    logic [2:0] alloc_tag;
    logic [1:0] cmpl_v;
    logic [2:0] cmpl_tag0;
    logic [2:0] cmpl_tag1;
    logic       flush;
    logic [2:0] W_v;
    logic       isHalt;
    logic [3:0] occupancy;

    int n_cmp;
    int n_bad;

    retire_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_v     (alloc_v),
        .alloc_halt  (alloc_halt),
        .alloc_ready (alloc_ready),
        .alloc_tag   (alloc_tag),
        .cmpl_v      (cmpl_v),
        .cmpl_tag0   (cmpl_tag0),
        .cmpl_tag1   (cmpl_tag1),
        .flush       (flush),
        .W_v         (W_v),
        .isHalt      (isHalt),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       av;
        bit       ah;
        bit [1:0] cv;
        int       t0;
        int       t1;
        bit       fl;
        int       w;
        int       ih;
        int       occ;
        int       rdy;
        int       tag;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit av, input bit ah, input bit [1:0] cv,
                                input int t0, input int t1, input bit fl,
                                input int w, input int ih, input int occ,
                                input int rdy, input int tag);
        vec_t v;
        v.av = av; v.ah = ah; v.cv = cv; v.t0 = t0; v.t1 = t1; v.fl = fl;
        v.w = w; v.ih = ih; v.occ = occ; v.rdy = rdy; v.tag = tag;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alloc_v = 0; alloc_halt = 0; cmpl_v = 0; cmpl_tag0 = 0; cmpl_tag1 = 0; flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 0;
        idle_inputs();

        // in-order drain: 5 allocations, done bits set youngest first
        for (int i = 1; i <= 5; i++) tbl.push_back(mk(1,0,2'b00,0,0,0, 0,0,i,1,i));
        tbl.push_back(mk(0,0,2'b11,4,3,0, 0,0,5,1,5));
        tbl.push_back(mk(0,0,2'b11,2,1,0, 0,0,5,1,5));
        tbl.push_back(mk(0,0,2'b11,0,0,0, 0,0,5,1,5));
        tbl.push_back(mk(0,0,2'b00,0,0,0, 3,0,2,1,5));
        tbl.push_back(mk(0,0,2'b00,0,0,0, 2,0,0,1,5));
        tbl.push_back(mk(0,0,2'b00,0,0,0, 0,0,0,1,5));
        // out-of-order block: tags 5,6,7, oldest withheld
        tbl.push_back(mk(1,0,2'b00,0,0,0, 0,0,1,1,6));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 0,0,2,1,7));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 0,0,3,1,0));
        tbl.push_back(mk(0,0,2'b01,7,0,0, 0,0,3,1,0));
        tbl.push_back(mk(0,0,2'b10,0,6,0, 0,0,3,1,0));
        tbl.push_back(mk(0,0,2'b00,0,0,0, 0,0,3,1,0));
        tbl.push_back(mk(0,0,2'b01,5,0,0, 0,0,3,1,0));
        tbl.push_back(mk(0,0,2'b00,0,0,0, 3,0,0,1,0));
        // fill to full, reject while full, retire and refill across 7 -> 0
        for (int i = 1; i <= 8; i++) tbl.push_back(mk(1,0,2'b00,0,0,0, 0,0,i,(i==8)?0:1,i%8));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 0,0,8,0,0));
        tbl.push_back(mk(0,0,2'b11,0,1,0, 0,0,8,0,0));
        tbl.push_back(mk(1,0,2'b11,2,3,0, 2,0,6,1,0));
        tbl.push_back(mk(0,0,2'b11,4,5,0, 2,0,4,1,0));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 2,0,3,1,1));
        tbl.push_back(mk(0,0,2'b11,7,0,0, 0,0,3,1,1));
        tbl.push_back(mk(0,0,2'b01,6,0,0, 0,0,3,1,1));
        tbl.push_back(mk(0,0,2'b00,0,0,0, 3,0,0,1,1));
        tbl.push_back(mk(0,0,2'b00,0,0,0, 0,0,0,1,1));
        // halt mid-window: plain, halt, plain
        tbl.push_back(mk(1,0,2'b00,0,0,0, 0,0,1,1,2));
        tbl.push_back(mk(1,1,2'b00,0,0,0, 0,0,2,1,3));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 0,0,3,1,4));
        tbl.push_back(mk(0,0,2'b11,1,2,0, 0,0,3,1,4));
        tbl.push_back(mk(0,0,2'b01,3,0,0, 2,1,1,0,4));
        tbl.push_back(mk(0,0,2'b00,0,0,0, 0,1,1,0,4));
        tbl.push_back(mk(1,0,2'b00,0,0,0, 0,1,1,0,4));
        tbl.push_back(mk(0,0,2'b00,0,0,1, 0,1,0,0,3));

        #12;
        chk("reset W_v", int'(W_v), 0);
        chk("reset isHalt", int'(isHalt), 0);
        chk("reset occupancy", int'(occupancy), 0);
        rst_n = 1;
        #1;
        chk("post-reset alloc_ready", int'(alloc_ready), 1);
        chk("post-reset alloc_tag", int'(alloc_tag), 0);
        @(posedge clk);
        #2;

        for (int k = 0; k < tbl.size(); k++) begin
            alloc_v    = tbl[k].av;
            alloc_halt = tbl[k].ah;
            cmpl_v     = tbl[k].cv;
            cmpl_tag0  = 3'(tbl[k].t0);
            cmpl_tag1  = 3'(tbl[k].t1);
            flush      = tbl[k].fl;
            step();
            chk($sformatf("v%0d W_v", k), int'(W_v), tbl[k].w);
            chk($sformatf("v%0d isHalt", k), int'(isHalt), tbl[k].ih);
            chk($sformatf("v%0d occupancy", k), int'(occupancy), tbl[k].occ);
            chk($sformatf("v%0d alloc_ready", k), int'(alloc_ready), tbl[k].rdy);
            chk($sformatf("v%0d alloc_tag", k), int'(alloc_tag), tbl[k].tag);
        end

        // asynchronous reset clears the sticky halt mid-cycle
        #1;
        rst_n = 0;
        #1;
        chk("async rst isHalt", int'(isHalt), 0);
        chk("async rst occupancy", int'(occupancy), 0);
        #2;
        rst_n = 1;
        @(posedge clk);
        #2;

        // flush precedence over allocate, complete and a pending retire
        for (int i = 0; i < 4; i++) begin
            alloc_v = 1;
            if (i == 3) begin
                cmpl_v = 2'b11; cmpl_tag0 = 0; cmpl_tag1 = 1;
            end
            step();
        end
        chk("pre-flush occupancy", int'(occupancy), 4);
        flush = 1; alloc_v = 1; cmpl_v = 2'b01; cmpl_tag0 = 2;
        #1;
        chk("flush alloc_ready", int'(alloc_ready), 0);
        step();
        chk("flush occupancy", int'(occupancy), 0);
        chk("flush W_v", int'(W_v), 0);
        chk("flush alloc_tag", int'(alloc_tag), 0);
        chk("flush alloc_ready after", int'(alloc_ready), 1);
        step();
        chk("post-flush W_v", int'(W_v), 0);
        chk("post-flush occupancy", int'(occupancy), 0);

        // async reset in the middle of a retirement
        for (int i = 0; i < 3; i++) begin
            alloc_v = 1;
            if (i == 2) begin
                cmpl_v = 2'b11; cmpl_tag0 = 0; cmpl_tag1 = 1;
            end
            step();
        end
        cmpl_v = 2'b01; cmpl_tag0 = 2;
        step();
        chk("mid-retire W_v", int'(W_v), 2);
        chk("mid-retire occupancy", int'(occupancy), 1);
        #1;
        rst_n = 0;
        #1;
        chk("async rst W_v", int'(W_v), 0);
        chk("async rst2 occupancy", int'(occupancy), 0);
        chk("async rst2 isHalt", int'(isHalt), 0);
        #3;
        rst_n = 1;
        #1;
        chk("release alloc_tag", int'(alloc_tag), 0);
        chk("release alloc_ready", int'(alloc_ready), 1);
        step();
        chk("release W_v", int'(W_v), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
